rx_control_module: RTL and testbench
====================================

# rx_control_module

UART receive sequencer for the RX path. Consumes the one-cycle falling-edge pulse from the RX edge detector as a start-of-frame trigger. Generates mid-bit sampling from a baud counter and shifts in an 8-bit LSB-first frame, optionally followed by an even-parity bit. Presents the byte with a one-cycle done pulse to the downstream consumer (FIFO or display logic).

## Interface
- BAUD_DIV, 434: CLK cycles per bit (50 MHz / 115200); legal range 4..65535
- CLK  in  1  system clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- H2L_Sig  in  1  one-cycle pulse: RX line high-to-low transition, from the edge detector
- RX_Pin_In  in  1  synchronised RX line, sampled mid-bit
- Rx_En_Sig  in  1  receive enable; level
- Rx_Data  out  8  last good received byte
- Rx_Done_Sig  out  1  one-cycle pulse: Rx_Data just updated
- Rx_Err_Sig  out  1  one-cycle pulse: frame rejected (stop/parity error)
- Rx_Busy  out  1  high while a frame is in progress
- Reset: one clock CLK; RSTn asynchronous, active-low; all outputs 0 under reset, state IDLE, counters 0

## Operation
- States: IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP.
- Baud counter bcnt, width ceil(log2(BAUD_DIV)); counts 0..BAUD_DIV-1, then wraps to 0; cleared on entry to START. Sample point: bcnt == BAUD_DIV/2 (integer divide). Bit boundary: bcnt == BAUD_DIV-1.
- IDLE: bcnt held 0. If Rx_En_Sig=1 and H2L_Sig=1 -> START. H2L_Sig is ignored while Rx_En_Sig=0 and in every non-IDLE state.
- START: at the sample point, if RX_Pin_In=1 (false start) -> IDLE, no pulses. Otherwise, at the bit boundary -> DATA, bit index 0.
- DATA: at the sample point, shift RX_Pin_In into the shift register LSB-first (bit i -> sr[i]). At the bit boundary, increment the index. After index 7 -> PARITY if enabled, else STOP.
- PARITY: sample at the sample point and store par_ok = (XOR of 8 data bits ^ sampled bit) == 0. At the bit boundary -> STOP.
- STOP: at the sample point, go -> IDLE directly, without waiting for the bit boundary. This re-arms start detection half a bit early.
  - Good frame (RX_Pin_In=1 and, if enabled, par_ok): Rx_Data <= shift register, Rx_Done_Sig=1 next cycle.
  - Otherwise: Rx_Err_Sig=1 next cycle; Rx_Data keeps its previous value.
- Rx_Done_Sig and Rx_Err_Sig are mutually exclusive and each lasts exactly one cycle.
- Rx_En_Sig falling mid-frame: the current frame completes normally. Only new starts are blocked.
- RSTn asserted mid-frame: immediate abort. State, counters and outputs return to reset values; no pulse is issued.
- Rx_Busy = (state != IDLE), registered.

## Timing
- Cycle 0: IDLE sees H2L_Sig=1 with Rx_En_Sig=1. Cycle 1: state=START, bcnt=0, Rx_Busy=1.
- Data bit i is sampled at cycle 1 + (i+1)*BAUD_DIV + BAUD_DIV/2.
- Without parity: the stop bit is sampled at cycle 1 + 9*BAUD_DIV + BAUD_DIV/2. Done/Err goes high at cycle 2 + 9*BAUD_DIV + BAUD_DIV/2, which is cycle 4125 for the default. Rx_Busy falls in the same cycle.
- With parity: add BAUD_DIV, giving cycle 4559 for the default.
- False start: return to IDLE at cycle 2 + BAUD_DIV/2.
- Rx_Data changes only in the cycle Rx_Done_Sig is high.

## Configuration
- RX_PARITY_EN
  - Defined: the frame carries a 9th, even-parity bit. The PARITY state exists, and a mismatch causes Rx_Err_Sig.
  - Undefined: there is no PARITY state, and the stop bit directly follows data bit 7.

## Test plan
- Assume BAUD_DIV=16 and no parity unless stated.
- Frame 0xA5 with a good stop bit -> Rx_Done_Sig single pulse at cycle 154, Rx_Data=0xA5, Rx_Err_Sig stays 0.
- Line low for only 4 cycles, then high -> return to IDLE at cycle 10. No Done/Err, Rx_Busy high for cycles 1..9, Rx_Data unchanged.
- Frame 0x3C with the stop bit driven 0 -> Rx_Err_Sig pulse at cycle 154, Rx_Data keeps 0xA5.
- Rx_En_Sig=0 with frame 0x55 -> no Busy, no pulses. Rx_En_Sig dropped at cycle 50 of frame 0x55 -> Done at 154, Rx_Data=0x55.
- RSTn pulsed low at cycle 80 mid-frame -> all outputs 0 immediately. The next frame 0x81 is received correctly.
- RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> Done at cycle 170.
  - 0x07 with parity bit 0 -> Err at cycle 170.

Source files
------------

// File: rtl/rx_control_module.sv
// UART receive sequencer: start qualification, mid-bit sampling, LSB-first 8-bit frame.
// Optional even-parity bit enabled by defining RX_PARITY_EN.
module rx_control_module #(
   parameter int BAUD_DIV = 434
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       H2L_Sig,
   input  logic       RX_Pin_In,
   input  logic       Rx_En_Sig,
   output logic [7:0] Rx_Data,
   output logic       Rx_Done_Sig,
   output logic       Rx_Err_Sig,
   output logic       Rx_Busy
);

   localparam int W = $clog2(BAUD_DIV);
   localparam logic [W-1:0] SAMPLE_PT = W'(BAUD_DIV / 2);
   localparam logic [W-1:0] BIT_END   = W'(BAUD_DIV - 1);
   localparam logic [W-1:0] BCNT_ONE  = W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   bcnt_q, bcnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     sr_q, sr_d;
   logic [7:0]     data_q, data_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic           busy_q;
   logic           at_sample_s;
   logic           at_end_s;
   logic           good_s;

`ifdef RX_PARITY_EN
   logic           par_ok_q, par_ok_d;

   // Even parity holds when data bits and parity bit XOR to zero.
   function automatic logic even_par_ok(input logic [7:0] d, input logic p);
      return ((^d) ^ p) == 1'b0;
   endfunction
`endif

   assign at_sample_s = (bcnt_q == SAMPLE_PT);
   assign at_end_s    = (bcnt_q == BIT_END);

   // Next-state, baud counter, shift register and pulse generation.
   always_comb begin
      state_d = state_q;
      bcnt_d  = at_end_s ? '0 : bcnt_q + BCNT_ONE;
      idx_d   = idx_q;
      sr_d    = sr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      good_s  = 1'b0;
`ifdef RX_PARITY_EN
      par_ok_d = par_ok_q;
`endif
      case (state_q)
         IDLE: begin
            bcnt_d = '0;
            idx_d  = 3'd0;
            if (Rx_En_Sig && H2L_Sig) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (at_sample_s && RX_Pin_In) begin
               state_d = IDLE;
               bcnt_d  = '0;
            end else if (at_end_s) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (at_sample_s) begin
               sr_d[idx_q] = RX_Pin_In;
            end else begin
               sr_d = sr_q;
            end
            if (at_end_s) begin
               if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (at_sample_s) begin
               par_ok_d = even_par_ok(sr_q, RX_Pin_In);
            end else begin
               par_ok_d = par_ok_q;
            end
            if (at_end_s) begin
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP: begin
            // Leave at mid-stop so the next start edge is not missed.
            if (at_sample_s) begin
               state_d = IDLE;
               bcnt_d  = '0;
`ifdef RX_PARITY_EN
               good_s  = RX_Pin_In && par_ok_q;
`else
               good_s  = RX_Pin_In;
`endif
               if (good_s) begin
                  data_d = sr_q;
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
            bcnt_d  = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         idx_q   <= 3'd0;
         sr_q    <= 8'h00;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
         par_ok_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= (state_d != IDLE);
`ifdef RX_PARITY_EN
         par_ok_q <= par_ok_d;
`endif
      end
   end

   assign Rx_Data     = data_q;
   assign Rx_Done_Sig = done_q;
   assign Rx_Err_Sig  = err_q;
   assign Rx_Busy     = busy_q;

endmodule

// File: tb/tb_rx_control_module.sv
// Bench for rx_control_module: frame table plus hand sequences, scoreboard of expected pulses.
module tb_rx_control_module;

   localparam int BD = 16;
`ifdef RX_PARITY_EN
   localparam int PULSE = 2 + 10 * BD + BD / 2;
`else
   localparam int PULSE = 2 + 9 * BD + BD / 2;
`endif

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       H2L_Sig = 1'b0;
   logic       RX_Pin_In = 1'b1;
   logic       Rx_En_Sig = 1'b1;
   logic [7:0] Rx_Data;
   logic       Rx_Done_Sig;
   logic       Rx_Err_Sig;
   logic       Rx_Busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] last_good = 8'h00;

   typedef struct {
      int         cyc;
      logic       err;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] d;
      logic       stop_b;
      logic       par_b;
   } vec_t;
   vec_t vecs[6];

   rx_control_module #(.BAUD_DIV(BD)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .H2L_Sig    (H2L_Sig),
      .RX_Pin_In  (RX_Pin_In),
      .Rx_En_Sig  (Rx_En_Sig),
      .Rx_Data    (Rx_Data),
      .Rx_Done_Sig(Rx_Done_Sig),
      .Rx_Err_Sig (Rx_Err_Sig),
      .Rx_Busy    (Rx_Busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every Done/Err pulse must match the oldest expectation.
   always @(negedge CLK) begin
      if (Rx_Done_Sig || Rx_Err_Sig) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'({Rx_Done_Sig, Rx_Err_Sig}), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            chk("pulse_kind_err", 32'(Rx_Err_Sig), 32'(e.err));
            chk("pulse_kind_done", 32'(Rx_Done_Sig), 32'(!e.err));
            chk("rx_data", 32'(Rx_Data), 32'(e.data));
            chk("busy_at_pulse", 32'(Rx_Busy), 32'd0);
         end
      end
   end

   function automatic logic line_bit(input int r, input logic [7:0] d,
                                     input logic p, input logic s);
      int k;
      if (r <= BD) return 1'b0;
      k = (r - 1) / BD - 1;
      if (k < 8) return d[k];
`ifdef RX_PARITY_EN
      if (k == 8) return p;
      k = k - 1;
`else
      if (p === 1'bx) return 1'b1;
`endif
      if (k == 8) return s;
      return 1'b1;
   endfunction

   task automatic idle(input int n);
      H2L_Sig   = 1'b0;
      RX_Pin_In = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic en, input int drop_at, input int rst_at);
      logic good;
      exp_t e;
      good = stop_b;
`ifdef RX_PARITY_EN
      good = stop_b && (((^d) ^ par_b) == 1'b0);
`endif
      Rx_En_Sig = en;
      if (en && rst_at < 0) begin
         if (good) last_good = d;
         e.cyc  = cyc + PULSE;
         e.err  = !good;
         e.data = last_good;
         sb.push_back(e);
      end
      for (int r = 0; r <= PULSE + 3; r++) begin
         H2L_Sig   = (r == 0) || (r == 60);
         RX_Pin_In = line_bit(r, d, par_b, stop_b);
         if (r == 1) chk("busy_after_start", 32'(Rx_Busy), 32'(en));
         if (r == drop_at) Rx_En_Sig = 1'b0;
         if (r == rst_at) begin
            RSTn = 1'b0;
            #1;
            chk("rst_busy", 32'(Rx_Busy), 32'd0);
            chk("rst_data", 32'(Rx_Data), 32'd0);
            chk("rst_pulses", 32'({Rx_Done_Sig, Rx_Err_Sig}), 32'd0);
            last_good = 8'h00;
         end
         if (rst_at >= 0 && r == rst_at + 3) RSTn = 1'b1;
         @(posedge CLK);
         #1;
      end
      Rx_En_Sig = 1'b1;
      idle(3);
   endtask

   initial begin
      vecs[0] = '{d: 8'hA5, stop_b: 1'b1, par_b: 1'b0};
      vecs[1] = '{d: 8'h3C, stop_b: 1'b0, par_b: 1'b0};
      vecs[2] = '{d: 8'h00, stop_b: 1'b1, par_b: 1'b0};
      vecs[3] = '{d: 8'hFF, stop_b: 1'b1, par_b: 1'b0};
      vecs[4] = '{d: 8'h5A, stop_b: 1'b0, par_b: 1'b0};
      vecs[5] = '{d: 8'h07, stop_b: 1'b1, par_b: 1'b1};

      repeat (3) @(posedge CLK);
      #1;
      chk("reset_busy", 32'(Rx_Busy), 32'd0);
      chk("reset_data", 32'(Rx_Data), 32'd0);
      chk("reset_done", 32'(Rx_Done_Sig), 32'd0);
      chk("reset_err", 32'(Rx_Err_Sig), 32'd0);
      RSTn = 1'b1;
      idle(3);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].d, vecs[i].stop_b, vecs[i].par_b, 1'b1, -1, -1);
      end
`ifdef RX_PARITY_EN
      run_frame(8'h07, 1'b1, 1'b0, 1'b1, -1, -1);
`endif
      run_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1);

      // False start: line low for 4 cycles only.
      H2L_Sig = 1'b1;
      for (int r = 0; r < 16; r++) begin
         RX_Pin_In = (r < 4) ? 1'b0 : 1'b1;
         @(posedge CLK);
         #1;
         H2L_Sig = 1'b0;
         chk("false_start_busy", 32'(Rx_Busy), 32'((r + 1) <= 9));
      end
      chk("false_start_data", 32'(Rx_Data), 32'(last_good));
      idle(3);

      run_frame(8'h55, 1'b1, 1'b0, 1'b0, -1, -1);
      chk("disabled_busy", 32'(Rx_Busy), 32'd0);
      run_frame(8'h55, 1'b1, 1'b0, 1'b1, 50, -1);
      run_frame(8'hC3, 1'b1, 1'b1, 1'b1, -1, 80);
      run_frame(8'h81, 1'b1, 1'b0, 1'b1, -1, -1);

      idle(5);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
